rs_bank: RTL
============

Name: rs_bank

Overview:
- Single reservation-station bank (one per FU category: ALU, MULT, BRANCH, MEM), directly upstream of the issue stage.
- Accepts renamed ops from dispatch and holds them until both sources are ready, snooping the CDB to do so.
- Exposes every entry every cycle so the issue-stage allocators can pick ready ones.
- Frees entries named by the issue stage's clear indices; flushes entirely on mispredict.

Parameters:
- NUM_ENTRIES, 8, entries in the bank (power of two, at least 2)
- DISPATCH_WIDTH, 2, ops accepted per cycle
- CDB_WIDTH, 3, CDB broadcasts snooped per cycle
- CLEAR_WIDTH, 2, issue clears per cycle (equals the FU count of the category)
- TAG_W, 6, physical register tag width
- PAYLOAD_W, 64, opaque op payload: opcode, immediate, PC, ROB index

Ports:
- clock  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-low
- mispredict  in  1  synchronous flush of all entries
- disp_valid  in  DISPATCH_WIDTH  per-slot dispatch request
- disp_src1_tag, disp_src2_tag, disp_dest_tag  in  DISPATCH_WIDTH*TAG_W  slot tags
- disp_src1_ready, disp_src2_ready  in  DISPATCH_WIDTH  source ready at rename
- disp_payload  in  DISPATCH_WIDTH*PAYLOAD_W  op payload
- free_count  out  $clog2(NUM_ENTRIES)+1  free entries in the registered state
- cdb_valid  in  CDB_WIDTH  broadcast valid
- cdb_tag  in  CDB_WIDTH*TAG_W  broadcast tag
- clear_valid  in  CLEAR_WIDTH  issue-stage clear valid
- clear_idx  in  CLEAR_WIDTH*$clog2(NUM_ENTRIES)  local entry index to free
- ent_valid, ent_src1_ready, ent_src2_ready  out  NUM_ENTRIES  registered entry state
- ent_src1_tag, ent_src2_tag, ent_dest_tag  out  NUM_ENTRIES*TAG_W  registered tags
- ent_payload  out  NUM_ENTRIES*PAYLOAD_W  registered payload
- overflow  out  1  sticky: a dispatch was dropped for lack of space

Behaviour:
- Reset (reset low, asynchronous): all entry fields 0, overflow 0, free_count = NUM_ENTRIES. Reset dominates mispredict.
- All ent_* outputs come straight from registers. Issue sees a dispatched op the cycle after disp_valid.
- Allocation:
  - Valid dispatch slots are processed in slot order (slot 0 first).
  - Each valid slot takes the lowest-index entry that is free in the registered state and not already taken by a lower slot.
  - Free means ent_valid = 0 at the start of the cycle. An entry cleared this cycle is not reusable until next cycle.
- Dispatch contract: the number of valid slots must be ≤ free_count. Excess slots are dropped, no entry is written, and overflow is set (sticky until reset).
- Source ready on write: a source is written ready if any of these hold:
  - its disp_srcN_ready is 1;
  - its tag is 0 (tag 0 is always ready);
  - it matches any valid cdb_tag in the same cycle (same-cycle bypass).
- Wakeup: every valid entry with srcN_ready = 0 sets srcN_ready when its tag equals any valid cdb_tag; several matches have the same effect as one. Ready bits never clear while an entry is valid.
- Clear: for each clear_valid[k], entry clear_idx[k] gets ent_valid = 0 next cycle; other fields may hold stale values.
  - Clearing an already-invalid entry is harmless.
  - Duplicate indices across k are legal.
  - A clear and a CDB wakeup on the same entry: clear wins.
- mispredict: every ent_valid goes to 0 next cycle; dispatch, wakeup and clear in that cycle are ignored. overflow is unaffected.
- free_count equals NUM_ENTRIES minus the number of ent_valid bits set, computed from registers (no combinational path from inputs).
- Full bank: free_count = 0, every dispatch is dropped and sets overflow. Issue clears still free entries for the following cycle.

Optional Feature:
- Macro: RS_BANK_PERF_EN.
- When defined, adds two outputs:
  - perf_full_cycles (32 bits): counts cycles with free_count = 0, saturating at all-ones.
  - perf_dispatched (32 bits): adds the number of successfully written entries each cycle, wrapping.
- Both counters reset to 0 on reset only; mispredict does not touch them.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset, then dispatch 2 ops with ready sources and srcs tags 5 and 0 → next cycle entries 0 and 1 valid, both sources ready, free_count = 6.
- Entry 0 waiting on tag 9 (src1_ready = 0), then cdb_valid[2] = 1 with cdb_tag[2] = 9 → next cycle ent_src1_ready[0] = 1, entries without tag 9 unchanged.
- Dispatch an op with src2_tag 12 not ready while cdb_tag[0] = 12 is valid in the same cycle → the entry is written with src2_ready = 1.
- Fill all 8 entries, then dispatch 1 more → dropped, overflow = 1, free_count = 0. Clear index 3 and dispatch in the same cycle → dispatch dropped. Next cycle's dispatch lands in entry 3.
- 5 valid entries, assert mispredict together with a dispatch and a CDB hit → next cycle all ent_valid = 0, free_count = 8.
- Drive reset low mid-cycle while entries are valid → outputs zero immediately without waiting for a clock edge. With RS_BANK_PERF_EN, 3 full cycles give perf_full_cycles = 3.

Source files
------------

// File: rtl/rs_bank.sv
// Reservation-station bank: holds renamed ops until both sources are ready, snooping the CDB.
// Optional RS_BANK_PERF_EN adds full-cycle and dispatched-op counters.
module rs_bank #(
  parameter int unsigned NUM_ENTRIES    = 8,
  parameter int unsigned DISPATCH_WIDTH = 2,
  parameter int unsigned CDB_WIDTH      = 3,
  parameter int unsigned CLEAR_WIDTH    = 2,
  parameter int unsigned TAG_W          = 6,
  parameter int unsigned PAYLOAD_W      = 64
) (
  input  logic                                       i_clock,
  input  logic                                       i_reset,
  input  logic                                       i_mispredict,
  input  logic [DISPATCH_WIDTH-1:0]                  i_disp_valid,
  input  logic [DISPATCH_WIDTH*TAG_W-1:0]            i_disp_src1_tag,
  input  logic [DISPATCH_WIDTH*TAG_W-1:0]            i_disp_src2_tag,
  input  logic [DISPATCH_WIDTH*TAG_W-1:0]            i_disp_dest_tag,
  input  logic [DISPATCH_WIDTH-1:0]                  i_disp_src1_ready,
  input  logic [DISPATCH_WIDTH-1:0]                  i_disp_src2_ready,
  input  logic [DISPATCH_WIDTH*PAYLOAD_W-1:0]        i_disp_payload,
  output logic [$clog2(NUM_ENTRIES):0]               o_free_count,
  input  logic [CDB_WIDTH-1:0]                       i_cdb_valid,
  input  logic [CDB_WIDTH*TAG_W-1:0]                 i_cdb_tag,
  input  logic [CLEAR_WIDTH-1:0]                     i_clear_valid,
  input  logic [CLEAR_WIDTH*$clog2(NUM_ENTRIES)-1:0] i_clear_idx,
  output logic [NUM_ENTRIES-1:0]                     o_ent_valid,
  output logic [NUM_ENTRIES-1:0]                     o_ent_src1_ready,
  output logic [NUM_ENTRIES-1:0]                     o_ent_src2_ready,
  output logic [NUM_ENTRIES*TAG_W-1:0]               o_ent_src1_tag,
  output logic [NUM_ENTRIES*TAG_W-1:0]               o_ent_src2_tag,
  output logic [NUM_ENTRIES*TAG_W-1:0]               o_ent_dest_tag,
  output logic [NUM_ENTRIES*PAYLOAD_W-1:0]           o_ent_payload,
`ifdef RS_BANK_PERF_EN
  output logic [31:0]                                o_perf_full_cycles,
  output logic [31:0]                                o_perf_dispatched,
`endif
  output logic                                       o_overflow
);

  localparam int unsigned IDX_W  = $clog2(NUM_ENTRIES);
  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned SLOT_W = (DISPATCH_WIDTH > 1) ? $clog2(DISPATCH_WIDTH) : 1;

  logic [NUM_ENTRIES-1:0] r_valid, r_s1_rdy, r_s2_rdy;
  logic [TAG_W-1:0]       r_s1_tag  [NUM_ENTRIES];
  logic [TAG_W-1:0]       r_s2_tag  [NUM_ENTRIES];
  logic [TAG_W-1:0]       r_dst_tag [NUM_ENTRIES];
  logic [PAYLOAD_W-1:0]   r_payload [NUM_ENTRIES];
  logic                   r_overflow;

  logic [TAG_W-1:0]        w_d_s1_tag  [DISPATCH_WIDTH];
  logic [TAG_W-1:0]        w_d_s2_tag  [DISPATCH_WIDTH];
  logic [TAG_W-1:0]        w_d_dst_tag [DISPATCH_WIDTH];
  logic [PAYLOAD_W-1:0]    w_d_payload [DISPATCH_WIDTH];
  logic [DISPATCH_WIDTH-1:0] w_d_s1_rdy, w_d_s2_rdy;

  logic [NUM_ENTRIES-1:0] w_alloc_mask, w_clear, w_s1_hit, w_s2_hit;
  logic [SLOT_W-1:0]      w_alloc_slot [NUM_ENTRIES];
  logic                   w_drop, w_found;
  logic [CNT_W-1:0]       w_used;

  function automatic logic cdb_hit(input logic [TAG_W-1:0]           tag,
                                   input logic [CDB_WIDTH-1:0]       vld,
                                   input logic [CDB_WIDTH*TAG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < CDB_WIDTH; c++) begin
      if (vld[c] && (tags[c*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Tag 0 and same-cycle CDB broadcasts make a source ready on write.
  always_comb begin
    for (int s = 0; s < DISPATCH_WIDTH; s++) begin
      w_d_s1_tag[s]  = i_disp_src1_tag[s*TAG_W +: TAG_W];
      w_d_s2_tag[s]  = i_disp_src2_tag[s*TAG_W +: TAG_W];
      w_d_dst_tag[s] = i_disp_dest_tag[s*TAG_W +: TAG_W];
      w_d_payload[s] = i_disp_payload[s*PAYLOAD_W +: PAYLOAD_W];
      w_d_s1_rdy[s]  = i_disp_src1_ready[s] || (w_d_s1_tag[s] == '0) ||
                       cdb_hit(w_d_s1_tag[s], i_cdb_valid, i_cdb_tag);
      w_d_s2_rdy[s]  = i_disp_src2_ready[s] || (w_d_s2_tag[s] == '0) ||
                       cdb_hit(w_d_s2_tag[s], i_cdb_valid, i_cdb_tag);
    end
  end

  // Slot-ordered allocation over entries free in the registered state only.
  always_comb begin
    w_alloc_mask = '0;
    w_drop       = 1'b0;
    w_found      = 1'b0;
    for (int e = 0; e < NUM_ENTRIES; e++) w_alloc_slot[e] = '0;
    for (int s = 0; s < DISPATCH_WIDTH; s++) begin
      if (i_disp_valid[s]) begin
        w_found = 1'b0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
          if (!w_found && !r_valid[e] && !w_alloc_mask[e]) begin
            w_alloc_mask[e] = 1'b1;
            w_alloc_slot[e] = SLOT_W'(s);
            w_found         = 1'b1;
          end
        end
        if (!w_found) w_drop = 1'b1;
      end
    end
  end

  always_comb begin
    w_clear = '0;
    for (int k = 0; k < CLEAR_WIDTH; k++) begin
      if (i_clear_valid[k]) w_clear[i_clear_idx[k*IDX_W +: IDX_W]] = 1'b1;
    end
  end

  always_comb begin
    w_used = '0;
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      w_s1_hit[e] = !r_s1_rdy[e] && cdb_hit(r_s1_tag[e], i_cdb_valid, i_cdb_tag);
      w_s2_hit[e] = !r_s2_rdy[e] && cdb_hit(r_s2_tag[e], i_cdb_valid, i_cdb_tag);
      w_used      = w_used + CNT_W'(r_valid[e]);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_valid    <= '0;
      r_s1_rdy   <= '0;
      r_s2_rdy   <= '0;
      r_overflow <= 1'b0;
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        r_s1_tag[e]  <= '0;
        r_s2_tag[e]  <= '0;
        r_dst_tag[e] <= '0;
        r_payload[e] <= '0;
      end
    end else if (i_mispredict) begin
      r_valid <= '0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        if (w_alloc_mask[e]) begin
          r_valid[e]   <= 1'b1;
          r_s1_tag[e]  <= w_d_s1_tag[w_alloc_slot[e]];
          r_s2_tag[e]  <= w_d_s2_tag[w_alloc_slot[e]];
          r_dst_tag[e] <= w_d_dst_tag[w_alloc_slot[e]];
          r_payload[e] <= w_d_payload[w_alloc_slot[e]];
          r_s1_rdy[e]  <= w_d_s1_rdy[w_alloc_slot[e]];
          r_s2_rdy[e]  <= w_d_s2_rdy[w_alloc_slot[e]];
        end else if (r_valid[e]) begin
          if (w_clear[e]) begin
            r_valid[e] <= 1'b0;
          end else begin
            if (w_s1_hit[e]) r_s1_rdy[e] <= 1'b1;
            if (w_s2_hit[e]) r_s2_rdy[e] <= 1'b1;
          end
        end
      end
    end
  end

  assign o_free_count     = CNT_W'(NUM_ENTRIES) - w_used;
  assign o_ent_valid      = r_valid;
  assign o_ent_src1_ready = r_s1_rdy;
  assign o_ent_src2_ready = r_s2_rdy;
  assign o_overflow       = r_overflow;

  for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_out
    assign o_ent_src1_tag[e*TAG_W +: TAG_W]         = r_s1_tag[e];
    assign o_ent_src2_tag[e*TAG_W +: TAG_W]         = r_s2_tag[e];
    assign o_ent_dest_tag[e*TAG_W +: TAG_W]         = r_dst_tag[e];
    assign o_ent_payload[e*PAYLOAD_W +: PAYLOAD_W]  = r_payload[e];
  end

`ifdef RS_BANK_PERF_EN
  logic [31:0]      r_perf_full, r_perf_disp;
  logic [CNT_W-1:0] w_n_alloc;

  always_comb begin
    w_n_alloc = '0;
    for (int e = 0; e < NUM_ENTRIES; e++) w_n_alloc = w_n_alloc + CNT_W'(w_alloc_mask[e]);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_perf_full <= '0;
      r_perf_disp <= '0;
    end else begin
      if ((w_used == CNT_W'(NUM_ENTRIES)) && (r_perf_full != '1)) r_perf_full <= r_perf_full + 32'd1;
      if (!i_mispredict) r_perf_disp <= r_perf_disp + 32'(w_n_alloc);
    end
  end

  assign o_perf_full_cycles = r_perf_full;
  assign o_perf_dispatched  = r_perf_disp;
`endif

endmodule
